// File: rtl/mwadd_pkg.sv
// Shared types for the multi-word add sequencer: FSM state encoding and index width helper.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int WORDS_DEFAULT = 4;
  localparam int IDX_W         = idx_width(WORDS_DEFAULT);

endpackage

// File: rtl/mwadd_seq_ctrl_ks_chunk_adder.sv
// Combinational N-bit Kogge-Stone adder; carry out is taken from the full-width group G/P.
module ks_chunk_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int LV = $clog2(N);

  logic [N-1:0] g_lv [LV+1];
  logic [N-1:0] p_lv [LV+1];
  logic [N-1:0] pb;
  logic [N-1:0] carry;

  assign pb      = a_i ^ b_i;
  assign g_lv[0] = a_i & b_i;
  assign p_lv[0] = pb;

  for (genvar k = 0; k < LV; k++) begin : g_level
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_merge
        assign g_lv[k+1][i] = g_lv[k][i] | (p_lv[k][i] & g_lv[k][i-(1<<k)]);
        assign p_lv[k+1][i] = p_lv[k][i] & p_lv[k][i-(1<<k)];
      end else begin : g_pass
        assign g_lv[k+1][i] = g_lv[k][i];
        assign p_lv[k+1][i] = p_lv[k][i];
      end
    end
  end

  // After the last level, bit i holds the group G/P of bits [i:0]; fold in cin.
  assign carry[0] = cin_i;
  for (genvar i = 1; i < N; i++) begin : g_carry
    assign carry[i] = g_lv[LV][i-1] | (p_lv[LV][i-1] & cin_i);
  end

  assign sum_o  = pb ^ carry;
  assign cout_o = g_lv[LV][N-1] | (p_lv[LV][N-1] & cin_i);

endmodule

// File: rtl/mwadd_seq_ctrl.sv
// Sequencer that adds WORDS*N-bit operands one N-bit chunk per cycle through a shared adder.
// Optional subtract mode is enabled with the MWADD_SUB_EN macro.
module mwadd_seq_ctrl
  import mwadd_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
`ifdef MWADD_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output state_e               state_dbg
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);

  // Handshake: a transfer happens on any rising edge where valid and ready are both high;
  // in_ready/out_valid depend only on state, never combinationally on the peer's signal.
  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   res_q, res_d, sum_q, sum_d;
  logic           carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   b_chunk, chunk_sum;
  logic           chunk_cout;
  logic [W-1:0]   res_shift;

`ifdef MWADD_SUB_EN
  logic sub_q, sub_d;
  assign b_chunk = b_q[N-1:0] ^ {N{sub_q}};
`else
  assign b_chunk = b_q[N-1:0];
`endif

  ks_chunk_adder #(.N(N)) u_adder (
    .a_i   (a_q[N-1:0]),
    .b_i   (b_chunk),
    .cin_i (carry_q),
    .sum_o (chunk_sum),
    .cout_o(chunk_cout)
  );

  // Result enters from the top so the first chunk ends up in the LSBs after WORDS shifts.
  if (WORDS > 1) begin : g_res_multi
    assign res_shift = {chunk_sum, res_q[W-1:N]};
  end else begin : g_res_single
    assign res_shift = chunk_sum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef MWADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          state_d = RUN;
`ifdef MWADD_SUB_EN
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
`else
          carry_d = cin;
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> N;
        b_d     = b_q >> N;
        res_d   = res_shift;
        carry_d = chunk_cout;
        if (idx_q == IW'(WORDS - 1)) begin
          state_d = DONE;
          sum_d   = res_shift;
          cout_d  = chunk_cout;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef MWADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef MWADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mwadd_seq_ctrl.sv
// Self-checking bench for mwadd_seq_ctrl (N=4, WORDS=4): vector table, corner sequences, random ops.
module tb_mwadd_seq_ctrl;
  import mwadd_pkg::*;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;
`ifdef MWADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, cin, sub;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] a, b, sum;
  state_e       state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[6];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  mwadd_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef MWADD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .state_dbg(state_dbg)
  );

  // reference model: plain arithmetic on whole operands
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic cv, input logic sv);
    logic [W:0] r;
    if (sv && SUB_EN) begin
      r[W-1:0] = av - bv;
      r[W]     = (av >= bv);
    end else begin
      r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // driver: one full operation, expected {cout,sum} supplied by caller
  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input logic [W:0] e_in);
    int lat;
    logic [W:0] e;
    lat = 0;
    while (!in_ready && lat < 20) begin
      cyc();
      lat++;
    end
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back(e_in);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = SUB_EN ? 1'($urandom) : 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(WORDS));
    e = exp_q.pop_front();
    chk({nm, " sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({nm, " cout"}, 32'(cout), 32'(e[W]));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({nm, " back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'h0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("idle rst in_ready", 32'(in_ready), 32'd1);
    chk("idle rst out_valid", 32'(out_valid), 32'd0);
    chk("idle rst sum", 32'(sum), 32'h0);

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
             {vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // DONE hold with back-pressure and ignored in_valid
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) cyc();
    for (int i = 0; i < 3; i++) begin
      a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
      chk($sformatf("hold%0d sum", i), 32'(sum), 32'h3333);
      chk($sformatf("hold%0d cout", i), 32'(cout), 32'd0);
      chk($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    run_op("after_hold", 16'h0001, 16'h0002, 1'b0, 1'b0, 17'h00003);

    // reset in RUN at idx=2
    a = 16'h1357; b = 16'h2468; cin = 1'b0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    chk("run idx2 out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort sum", 32'(sum), 32'h0);
    chk("abort cout", 32'(cout), 32'd0);
    cyc();
    chk("abort stays idle", 32'(state_dbg), 32'(IDLE));
    run_op("post_abort", 16'h00F0, 16'h0010, 1'b0, 1'b0, 17'h00100);

    if (SUB_EN) begin
      run_op("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
      run_op("sub 7-5", 16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002);
      run_op("sub 5-7 cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE);
      run_op("sub 7-5 cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002);
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
